// File: rtl/m_ifetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m_ifetch_queue
// Brief    : Instruction-fetch front end. It drives a 1-cycle synchronous
//            instruction memory and buffers fetched {ir, pc} words in a
//            prefetch FIFO that feeds ID over a valid/ready handshake.
//            Define IFQ_BYPASS_EN to forward a returning word straight to ID
//            when the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module m_ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 12,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic                         w_clk,
  input  logic                         w_rst_n,
  input  logic                         w_flush,
  input  logic [31:0]                  w_tpc,
  input  logic                         w_halt,
  output logic [AW-1:0]                w_imem_addr,
  input  logic [31:0]                  w_imem_rdata,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [31:0]                  w_ir,
  output logic [31:0]                  w_pc,
  output logic [31:0]                  w_pc4,
  output logic [$clog2(DEPTH+1)-1:0]   w_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);

  logic [31:0]        r_fpc;
  logic [31:0]        r_ipc;
  logic               r_inflight;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_ir [DEPTH];
  logic [31:0]        r_pc [DEPTH];

  logic [c_cnt_w:0]   w_occ;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_byp;

  // Occupancy counts the outstanding read so a returning word always has a slot.
  assign w_occ   = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_issue = !w_halt && !w_flush && (w_occ < (c_cnt_w+1)'(DEPTH));

`ifdef IFQ_BYPASS_EN
  assign w_byp = (r_count == '0) && r_inflight && !w_flush;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed word that ID accepts this edge is consumed, never written.
  assign w_push = r_inflight && !w_flush && !(w_byp && w_ready);
  assign w_pop  = (r_count != '0) && w_ready && !w_flush;

  assign w_valid     = (r_count != '0) || w_byp;
  assign w_ir        = w_byp ? w_imem_rdata : r_ir[r_rptr];
  assign w_pc        = w_byp ? r_ipc : r_pc[r_rptr];
  assign w_pc4       = w_pc + 32'd4;
  assign w_count     = r_count;
  assign w_imem_addr = r_fpc[AW+1:2];

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fpc      <= PC_RESET;
      r_ipc      <= 32'h0;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (w_flush) begin
      r_fpc      <= w_tpc;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      if (w_push && !w_pop)
        r_count <= r_count + c_cnt_w'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - c_cnt_w'(1);
      if (w_issue) begin
        r_inflight <= 1'b1;
        r_ipc      <= r_fpc;
        r_fpc      <= r_fpc + 32'd4;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // Storage carries no reset; entries are only observed once written.
  always_ff @(posedge w_clk) begin
    if (w_push) begin
      r_ir[r_wptr] <= w_imem_rdata;
      r_pc[r_wptr] <= r_ipc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_ifetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_m_ifetch_queue
// Brief    : Scoreboard bench for m_ifetch_queue; the reference model is the
//            program-order PC stream restarted at every redirect or reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_ifetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 12;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_flush = 1'b0;
  logic [31:0] w_tpc = 32'h0;
  logic        w_halt = 1'b0;
  logic [AW-1:0] w_imem_addr;
  logic [31:0] w_imem_rdata = 32'h0;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_ir, w_pc, w_pc4;
  logic [2:0]  w_count;

  int n_pass = 0;
  int n_total = 0;
  int hs_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = 32'h0;

  m_ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .PC_RESET(32'h0)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_flush(w_flush), .w_tpc(w_tpc),
    .w_halt(w_halt), .w_imem_addr(w_imem_addr), .w_imem_rdata(w_imem_rdata),
    .w_valid(w_valid), .w_ready(w_ready), .w_ir(w_ir), .w_pc(w_pc),
    .w_pc4(w_pc4), .w_count(w_count)
  );

  always #5 w_clk = ~w_clk;

  // Synchronous instruction memory: word i holds 0x1000_0000 + i.
  always @(posedge w_clk) w_imem_rdata <= 32'h1000_0000 + 32'(w_imem_addr);

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + 32'(pc[AW+1:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    topup();
  endtask

  // Monitor: every accepted instruction must be the next one in program order.
  always @(negedge w_clk) begin
    logic [31:0] e;
    if (w_rst_n) begin
      check("count_le_depth", 32'(w_count <= 3'(DEPTH)), 32'd1);
      if (w_valid && w_ready && !w_flush) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL stream_empty: got pc %h expected none", w_pc);
        end else begin
          e = exp_q.pop_front();
          check("stream_pc", w_pc, e);
          check("stream_ir", w_ir, word_at(e));
          check("stream_pc4", w_pc4, e + 32'd4);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge w_clk);
    #1;
    topup();
  endtask

  task automatic at_neg();
    @(negedge w_clk);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic apply_reset();
    @(posedge w_clk);
    #3;
    w_rst_n = 1'b0;
    w_flush = 1'b0;
    #1;
    check("rst_valid", 32'(w_valid), 32'd0);
    check("rst_count", 32'(w_count), 32'd0);
    check("rst_addr", 32'(w_imem_addr), 32'd0);
    redirect(32'h0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int gaps;
    int hs0;
    logic [31:0] p;
    logic [31:0] exp_addr;
    redirect(32'h0);

    // A: streaming from reset.
    w_ready = 1'b1;
    apply_reset();
    cyc();
    at_neg();
`ifdef IFQ_BYPASS_EN
    check("A_valid_e1", 32'(w_valid), 32'd1);
    check("A_ir_e1", w_ir, 32'h1000_0000);
`else
    check("A_valid_e1", 32'(w_valid), 32'd0);
`endif
    cyc();
    at_neg();
    check("A_valid_e2", 32'(w_valid), 32'd1);
`ifndef IFQ_BYPASS_EN
    check("A_ir_e2", w_ir, 32'h1000_0000);
    check("A_pc_e2", w_pc, 32'h0);
    check("A_pc4_e2", w_pc4, 32'h4);
`endif
    gaps = 0;
    repeat (8) begin
      cyc();
      at_neg();
      if (!w_valid) gaps++;
    end
    check("A_gaps", 32'(gaps), 32'd0);

    // B: ID stalled from reset; FIFO fills, then drains in order.
    w_ready = 1'b0;
    apply_reset();
    repeat (8) cyc();
    at_neg();
    check("B_count_full", 32'(w_count), 32'd4);
    check("B_addr_stop", 32'(w_imem_addr), 32'd4);
    cyc();
    w_ready = 1'b1;
    gaps = 0;
    repeat (10) begin
      at_neg();
      if (!w_valid) gaps++;
      cyc();
    end
    check("B_gap_le1", 32'(gaps <= 1), 32'd1);

    // C: redirect mid-stream.
    w_ready = 1'b1;
    apply_reset();
    repeat (6) cyc();
    w_flush = 1'b1;
    w_tpc = 32'h40;
    redirect(32'h40);
    cyc();
    w_flush = 1'b0;
    at_neg();
    check("C_count_flush", 32'(w_count), 32'd0);
    check("C_valid_flush", 32'(w_valid), 32'd0);
    cyc();
    at_neg();
`ifdef IFQ_BYPASS_EN
    check("C_valid_f1", 32'(w_valid), 32'd1);
    check("C_pc_f1", w_pc, 32'h40);
    check("C_ir_f1", w_ir, 32'h1000_0010);
`else
    check("C_valid_f1", 32'(w_valid), 32'd0);
`endif
    cyc();
    at_neg();
    check("C_valid_f2", 32'(w_valid), 32'd1);
`ifndef IFQ_BYPASS_EN
    check("C_pc_f2", w_pc, 32'h40);
    check("C_ir_f2", w_ir, 32'h1000_0010);
`endif

    // D: halt with ID stalled, then drain, then resume.
    repeat (4) cyc();
    p = exp_q[0];
    w_halt = 1'b1;
    w_ready = 1'b0;
`ifdef IFQ_BYPASS_EN
    exp_addr = (p + 32'd4) >> 2;
`else
    exp_addr = (p + 32'd8) >> 2;
`endif
    repeat (4) cyc();
    at_neg();
`ifdef IFQ_BYPASS_EN
    check("D_count_halt", 32'(w_count), 32'd1);
`else
    check("D_count_halt", 32'(w_count), 32'd2);
`endif
    check("D_addr_halt", 32'(w_imem_addr), exp_addr);
    cyc();
    w_ready = 1'b1;
    repeat (8) cyc();
    at_neg();
    check("D_valid_drained", 32'(w_valid), 32'd0);
    check("D_count_drained", 32'(w_count), 32'd0);
    check("D_addr_held", 32'(w_imem_addr), exp_addr);
    cyc();
    w_halt = 1'b0;
    hs0 = hs_count;
    repeat (5) cyc();
    check("D_resumed", 32'(hs_count - hs0 >= 2), 32'd1);

    // E: asynchronous reset mid-stream; restart at pc 0 is scoreboarded.
    apply_reset();
    hs0 = hs_count;
    repeat (6) cyc();
    check("E_restart_hs", 32'(hs_count - hs0 >= 4), 32'd1);

    // Randomized traffic against the program-order model.
    for (int i = 0; i < 2000; i++) begin
      cyc();
      w_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 5) w_halt = ~w_halt;
      if ($urandom_range(0, 99) < 3) begin
        w_flush = 1'b1;
        w_tpc = 32'($urandom_range(0, 1023)) << 2;
        redirect(w_tpc);
      end else begin
        w_flush = 1'b0;
      end
      if ($urandom_range(0, 999) == 0) apply_reset();
    end
    cyc();
    w_flush = 1'b0;
    w_halt = 1'b0;
    w_ready = 1'b1;
    hs0 = hs_count;
    repeat (10) cyc();
    check("R_live", 32'(hs_count - hs0 >= 6), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/m_ifetch_queue.md
Name: m_ifetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the ID stage of the 5-stage pipeline.
- Drives the synchronous instruction memory (1-cycle read latency) and buffers fetched words with their PC and PC+4 in a small prefetch FIFO.
- Presents instructions to ID over a valid/ready handshake.
- Redirects on taken branch (flush + target) and stops issuing on halt.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- AW, 12, instruction-memory word-address width.
- PC_RESET, 32'h0, fetch PC after reset.

Ports:
- w_clk  in  1  clock, all state updates on posedge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_flush  in  1  taken-branch redirect from ID.
- w_tpc  in  32  redirect target, sampled when w_flush=1.
- w_halt  in  1  level; while 1 no new fetches are issued.
- w_imem_addr  out  AW  word address = r_fpc[AW+1:2].
- w_imem_rdata  in  32  memory data; valid the cycle after issue.
- w_valid  out  1  head entry valid.
- w_ready  in  1  ID accepts head this cycle.
- w_ir  out  32  head instruction.
- w_pc  out  32  head PC.
- w_pc4  out  32  head PC+4.
- w_count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- State:
  - r_fpc: next fetch PC.
  - r_inflight (1b): a read is outstanding.
  - r_ipc: PC of the outstanding read.
  - FIFO: DEPTH x {ir, pc}, with rd/wr pointers and count. pc4 is computed from the head pc.
- Issue condition: w_issue = !w_halt && !w_flush && (count + r_inflight) < DEPTH.
  - The check is conservative and ignores a same-cycle pop.
  - On an issuing edge: r_inflight<=1, r_ipc<=r_fpc, r_fpc<=r_fpc+4 (32-bit wrap).
  - On a non-issuing edge: r_inflight<=0.
- Push: on an edge with r_inflight=1 and w_flush=0, write {w_imem_rdata, r_ipc} at the write pointer.
- Pop: on an edge with w_valid && w_ready, advance the read pointer.
- Simultaneous push and pop leave count unchanged.
- Pointers wrap modulo DEPTH.
- w_valid = (count != 0). Head outputs are driven combinationally from the FIFO registers. When w_valid=0, w_ir/w_pc/w_pc4 are don't-care.
- Latency: issue at edge k, push at edge k+1, w_valid=1 after edge k+1. Sustained throughput is 1 instruction/cycle while w_ready=1.
- Flush has priority over everything in the same cycle:
  - count<=0, pointers<=0, r_inflight<=0, so the returning word is discarded.
  - r_fpc<=w_tpc; no issue this cycle; the next issue is at w_tpc.
  - A pop presented in the flush cycle is ignored; ID treats its instruction as squashed.
- Halt:
  - Issue stops; an outstanding read is still pushed; the FIFO drains normally.
  - A flush during halt updates r_fpc but does not issue.
  - Deasserting halt resumes at r_fpc.
- Full: push into a full FIFO is impossible by construction. The bench asserts count<=DEPTH and never push-when-full.
- Empty: w_ready with count==0 has no effect.
- Reset, asynchronous and valid mid-operation:
  - count=0, pointers=0, r_inflight=0, r_fpc=PC_RESET, r_ipc=0.
  - w_valid=0, w_count=0.
  - w_imem_addr=PC_RESET[AW+1:2].
  - FIFO storage need not be cleared.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- With it defined:
  - When count==0 and r_inflight=1 and w_flush=0, the head outputs come combinationally from {w_imem_rdata, r_ipc} and w_valid=1.
  - If w_ready=1 that edge, the word is consumed and not pushed; otherwise it is pushed normally.
  - Issue-to-valid latency becomes 1 cycle (valid during cycle k+1).
- Without it: behaviour exactly as above, with valid only after the push.

Test Plan:
- Memory model: word i = 32'h1000_0000+i.
- Reset then w_ready=1, halt/flush low:
  - Without bypass: first w_valid after 2nd edge with w_ir=32'h1000_0000, w_pc=0, w_pc4=4.
  - Then one instruction per cycle: pc 4, 8, 12 with ir ...0001, ...0002, ...0003.
- Hold w_ready=0 from reset:
  - w_count saturates at 4 (DEPTH); w_imem_addr stops at 4.
  - Release w_ready: drains pc 0, 4, 8, 12 in order, then fetch continues at pc 16 without a gap beyond 1 cycle.
- Steady stream, assert w_flush with w_tpc=32'h40 for 1 cycle:
  - Next edge w_count=0 and w_valid=0; the in-flight word is dropped.
  - 2 edges later w_pc=32'h40, w_ir=32'h1000_0010; no stale PC is ever presented.
- w_halt=1 with w_ready=0:
  - At most one further push occurs, then w_imem_addr stays constant.
  - With w_ready=1, the FIFO empties, w_valid=0, and no further issue.
  - Deassert halt: fetch resumes from the held PC.
- Assert w_rst_n=0 mid-stream between clock edges:
  - Outputs clear immediately: w_valid=0, w_count=0, w_imem_addr=0.
  - After release, sequence restarts at pc 0.
- With IFQ_BYPASS_EN defined:
  - Reset then w_ready=1: w_valid=1 in the cycle after the first issue, with w_ir=32'h1000_0000.
  - Flush to 32'h40: w_pc=32'h40 presented 1 cycle earlier than without bypass.
